b_stage: RTL and testbench

B_STAGE -- requirements
Module: b_stage

---
 rtl/b_stage_if.sv | 33 +++
 rtl/b_stage.sv | 121 ++++++++++++
 tb/tb_b_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/b_stage_if.sv
// b_stage_if: handshake bundle for the b_stage routing stage.
//   slave  : the routing stage. It drives Ack_out, the route outputs and the counters.
//   master : the environment. It drives Send_in, PACKET_IN, Ack_in_EX and Ack_in_IN.
// Signals:
//   Send_in/PACKET_IN/Ack_out         upstream packet and its accept
//   Send_out_EX/PACKET_OUT_EX/Ack_in_EX  external route
//   Send_out_IN/PACKET_OUT_IN/Ack_in_IN  internal route
//   CNT_EX/CNT_IN                     delivered-packet counters
interface b_stage_if;
    logic        Send_in;
    logic [37:0] PACKET_IN;
    logic        Ack_out;
    logic        Send_out_EX;
    logic [37:0] PACKET_OUT_EX;
    logic        Ack_in_EX;
    logic        Send_out_IN;
    logic [37:0] PACKET_OUT_IN;
    logic        Ack_in_IN;
    logic [15:0] CNT_EX;
    logic [15:0] CNT_IN;

    modport slave (
        input  Send_in, PACKET_IN, Ack_in_EX, Ack_in_IN,
        output Ack_out, Send_out_EX, PACKET_OUT_EX, Send_out_IN, PACKET_OUT_IN,
               CNT_EX, CNT_IN
    );

    modport master (
        output Send_in, PACKET_IN, Ack_in_EX, Ack_in_IN,
        input  Ack_out, Send_out_EX, PACKET_OUT_EX, Send_out_IN, PACKET_OUT_IN,
               CNT_EX, CNT_IN
    );
endinterface

// File: rtl/b_stage.sv
// b_stage: routing stage with two outputs.
// Each packet is steered by its destination field, PACKET_IN[37:32]:
//   - it goes to the internal route when that field equals NODE_ID;
//   - otherwise it goes to the external route.
// Each route has a 2-entry FIFO and a 16-bit counter of delivered packets.
// Ports:
//   CLK   rising-edge clock
//   MR_N  asynchronous active-low master reset
//   bus   b_stage_if.slave (upstream, EX route, IN route, counters)

// b_stage_fifo: 2-entry FIFO for one route.
//   push/pop   qualified requests from the top
//   din        packet to write
//   full       occupancy == 2
//   vld        occupancy != 0
//   head       oldest entry, or zero when empty
//   cnt        wrapping count of pops
module b_stage_fifo #(
    parameter int W = 38
) (
    input  logic         CLK,
    input  logic         MR_N,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         vld,
    output logic [W-1:0] head,
    output logic [15:0]  cnt
);
    logic [1:0]        occ;
    logic [1:0][W-1:0] mem;   // mem[0] is the head
    logic              push_ok;
    logic              pop_ok;

    assign full    = (occ == 2'd2);
    assign vld     = (occ != 2'd0);
    assign head    = vld ? mem[0] : '0;
    // Guard again locally so the FIFO can never over- or under-run.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & vld;

    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            occ <= 2'd0;
            mem <= '0;
            cnt <= 16'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (occ == 2'd0) mem[0] <= din;
                    else             mem[1] <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    mem[0] <= mem[1];
                    mem[1] <= '0;
                    occ    <= occ - 2'd1;
                end
                // Both requests can be granted only at occupancy 1.
                // The new packet replaces the departing head, so no bubble is created.
                2'b11: mem[0] <= din;
                default: ;
            endcase
            if (pop_ok) cnt <= cnt + 16'd1;
        end
    end
endmodule

module b_stage #(
    parameter logic [5:0] NODE_ID = 6'd0
) (
    input  logic     CLK,
    input  logic     MR_N,
    b_stage_if.slave bus
);
    localparam int NUM_ROUTES = 2;   // route 0 = EX, route 1 = IN
    localparam int PKT_W      = 38;

    logic                             is_int;
    logic [NUM_ROUTES-1:0]            push;
    logic [NUM_ROUTES-1:0]            pop;
    logic [NUM_ROUTES-1:0]            full;
    logic [NUM_ROUTES-1:0]            vld;
    logic [NUM_ROUTES-1:0][PKT_W-1:0] head;
    logic [NUM_ROUTES-1:0][15:0]      cnt;
    logic [NUM_ROUTES-1:0]            ack_in;

    // Ack_out depends only on the current destination and the occupancy.
    // Downstream acks are not used here, so a full route does not accept
    // even on the edge at which it pops.
    assign is_int      = (bus.PACKET_IN[37:32] == NODE_ID);
    assign bus.Ack_out = is_int ? ~full[1] : ~full[0];

    assign push[0] = bus.Send_in & bus.Ack_out & ~is_int;
    assign push[1] = bus.Send_in & bus.Ack_out &  is_int;

    assign ack_in = {bus.Ack_in_IN, bus.Ack_in_EX};
    assign pop    = ack_in & vld;

    for (genvar g = 0; g < NUM_ROUTES; g++) begin : g_route
        b_stage_fifo #(.W(PKT_W)) u_fifo (
            .CLK  (CLK),
            .MR_N (MR_N),
            .push (push[g]),
            .pop  (pop[g]),
            .din  (bus.PACKET_IN),
            .full (full[g]),
            .vld  (vld[g]),
            .head (head[g]),
            .cnt  (cnt[g])
        );
    end

    assign bus.Send_out_EX   = vld[0];
    assign bus.PACKET_OUT_EX = head[0];
    assign bus.CNT_EX        = cnt[0];
    assign bus.Send_out_IN   = vld[1];
    assign bus.PACKET_OUT_IN = head[1];
    assign bus.CNT_IN        = cnt[1];
endmodule

// File: tb/tb_b_stage.sv
module tb_b_stage;
    logic clk = 1'b0;
    logic mr_n;
    always #5 clk = ~clk;

    b_stage_if bus();

    b_stage #(.NODE_ID(6'd5)) dut (
        .CLK  (clk),
        .MR_N (mr_n),
        .bus  (bus)
    );

    // Reference model: one queue per route plus the expected counters.
    logic [37:0] q_ex[$];
    logic [37:0] q_in[$];
    logic [15:0] m_cnt_ex;
    logic [15:0] m_cnt_in;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic to_int(input logic [37:0] p);
        return p[37:32] == 6'd5;
    endfunction

    function automatic logic exp_ack(input logic [37:0] p);
        if (to_int(p)) return q_in.size() < 2;
        else           return q_ex.size() < 2;
    endfunction

    task automatic model_reset();
        q_ex.delete();
        q_in.delete();
        m_cnt_ex = 16'd0;
        m_cnt_in = 16'd0;
    endtask

    task automatic check_outputs();
        logic [37:0] h_ex;
        logic [37:0] h_in;
        h_ex = (q_ex.size() != 0) ? q_ex[0] : 38'd0;
        h_in = (q_in.size() != 0) ? q_in[0] : 38'd0;
        chk("ack_out",  64'(bus.Ack_out),       64'(exp_ack(bus.PACKET_IN)));
        chk("send_ex",  64'(bus.Send_out_EX),   64'(q_ex.size() != 0));
        chk("send_in",  64'(bus.Send_out_IN),   64'(q_in.size() != 0));
        chk("pkt_ex",   64'(bus.PACKET_OUT_EX), 64'(h_ex));
        chk("pkt_in",   64'(bus.PACKET_OUT_IN), 64'(h_in));
        chk("cnt_ex",   64'(bus.CNT_EX),        64'(m_cnt_ex));
        chk("cnt_in",   64'(bus.CNT_IN),        64'(m_cnt_in));
    endtask

    // One clock cycle. Inputs are driven at negedge, checked 1 time unit later,
    // and the model advances at the following posedge.
    task automatic step(input logic s, input logic [37:0] p, input logic aex, input logic ain);
        logic pop_ex, pop_in, psh;
        bus.Send_in   = s;
        bus.PACKET_IN = p;
        bus.Ack_in_EX = aex;
        bus.Ack_in_IN = ain;
        #1;
        check_outputs();
        pop_ex = (q_ex.size() != 0) && aex;
        pop_in = (q_in.size() != 0) && ain;
        psh    = s && exp_ack(p);
        @(posedge clk);
        if (pop_ex) begin void'(q_ex.pop_front()); m_cnt_ex++; end
        if (pop_in) begin void'(q_in.pop_front()); m_cnt_in++; end
        if (psh) begin
            if (to_int(p)) q_in.push_back(p);
            else           q_ex.push_back(p);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [37:0] p;
        logic [5:0]  d;
        model_reset();
        mr_n          = 1'b0;
        bus.Send_in   = 1'b1;
        bus.PACKET_IN = {6'd5, 32'h1};
        bus.Ack_in_EX = 1'b0;
        bus.Ack_in_IN = 1'b0;
        #1;
        chk("rst_ack",     64'(bus.Ack_out), 64'd1);
        chk("rst_send_ex", 64'(bus.Send_out_EX), 64'd0);
        chk("rst_send_in", 64'(bus.Send_out_IN), 64'd0);
        chk("rst_pkt_ex",  64'(bus.PACKET_OUT_EX), 64'd0);
        chk("rst_pkt_in",  64'(bus.PACKET_OUT_IN), 64'd0);
        chk("rst_cnt_ex",  64'(bus.CNT_EX), 64'd0);
        chk("rst_cnt_in",  64'(bus.CNT_IN), 64'd0);
        // Hold Send_in across a clock edge while in reset; nothing may be pushed.
        @(posedge clk);
        @(negedge clk);
        chk("rst_nopush", 64'(bus.Send_out_IN), 64'd0);
        mr_n = 1'b1;

        // Internal route with 1-cycle latency.
        step(1'b1, {6'd5, 32'hA5A5A5A5}, 1'b0, 1'b1);
        chk("r31_send_in", 64'(bus.Send_out_IN), 64'd1);
        chk("r31_pkt_in",  64'(bus.PACKET_OUT_IN), 64'({6'd5, 32'hA5A5A5A5}));
        chk("r31_send_ex", 64'(bus.Send_out_EX), 64'd0);
        step(1'b0, 38'd0, 1'b0, 1'b1);
        chk("r31_cnt_in",  64'(bus.CNT_IN), 64'd1);

        // External route: fill it, stall the third packet, then drain in order.
        step(1'b1, {6'd9, 32'h1}, 1'b0, 1'b0);
        step(1'b1, {6'd9, 32'h2}, 1'b0, 1'b0);
        bus.PACKET_IN = {6'd9, 32'h3};
        #1;
        chk("r32_ack_full", 64'(bus.Ack_out), 64'd0);
        step(1'b1, {6'd9, 32'h3}, 1'b0, 1'b0);
        chk("r32_head1", 64'(bus.PACKET_OUT_EX), 64'({6'd9, 32'h1}));
        step(1'b1, {6'd9, 32'h3}, 1'b1, 1'b0);   // pop 1; ack still low this cycle
        chk("r32_head2", 64'(bus.PACKET_OUT_EX), 64'({6'd9, 32'h2}));
        step(1'b1, {6'd9, 32'h3}, 1'b1, 1'b0);   // pop 2, push 3
        chk("r32_head3", 64'(bus.PACKET_OUT_EX), 64'({6'd9, 32'h3}));
        step(1'b0, 38'd0, 1'b1, 1'b0);
        chk("r32_cnt_ex", 64'(bus.CNT_EX), 64'd3);
        chk("r32_empty",  64'(bus.Send_out_EX), 64'd0);

        // Push and pop on the same edge at occupancy 1.
        step(1'b1, {6'd5, 32'h10}, 1'b0, 1'b0);
        step(1'b1, {6'd5, 32'h7}, 1'b0, 1'b1);
        chk("r33_send_in", 64'(bus.Send_out_IN), 64'd1);
        chk("r33_head",    64'(bus.PACKET_OUT_IN), 64'({6'd5, 32'h7}));
        step(1'b0, 38'd0, 1'b0, 1'b1);
        chk("r33_drained", 64'(bus.Send_out_IN), 64'd0);

        // EX is full while IN is empty: Ack_out follows the current destination.
        step(1'b1, {6'd9, 32'hA}, 1'b0, 1'b0);
        step(1'b1, {6'd9, 32'hB}, 1'b0, 1'b0);
        bus.PACKET_IN = {6'd9, 32'hC};
        #1;
        chk("r34_ack_ex_full", 64'(bus.Ack_out), 64'd0);
        bus.PACKET_IN = {6'd5, 32'hD};
        #1;
        chk("r34_ack_in_free", 64'(bus.Ack_out), 64'd1);
        step(1'b1, {6'd5, 32'hD}, 1'b0, 1'b0);
        chk("r34_accepted", 64'(bus.PACKET_OUT_IN), 64'({6'd5, 32'hD}));
        step(1'b0, 38'd0, 1'b1, 1'b1);
        step(1'b0, 38'd0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(2))
                0:       d = 6'd5;
                1:       d = 6'd9;
                default: d = 6'($urandom);
            endcase
            p = {d, 32'($urandom)};
            step(1'($urandom_range(1)), p, ($urandom_range(3) != 0), ($urandom_range(3) != 0));
        end

        // Mid-operation async reset with both FIFOs full.
        step(1'b0, 38'd0, 1'b1, 1'b1);
        step(1'b0, 38'd0, 1'b1, 1'b1);
        step(1'b1, {6'd9, 32'h11}, 1'b0, 1'b0);
        step(1'b1, {6'd9, 32'h12}, 1'b0, 1'b0);
        step(1'b1, {6'd5, 32'h21}, 1'b0, 1'b0);
        step(1'b1, {6'd5, 32'h22}, 1'b0, 1'b0);
        chk("r36_full_ex", 64'(q_ex.size()), 64'd2);
        chk("r36_full_in", 64'(q_in.size()), 64'd2);
        bus.Send_in = 1'b0;
        #2;
        mr_n = 1'b0;
        #1;
        model_reset();
        chk("r36_send_ex", 64'(bus.Send_out_EX), 64'd0);
        chk("r36_send_in", 64'(bus.Send_out_IN), 64'd0);
        chk("r36_pkt_ex",  64'(bus.PACKET_OUT_EX), 64'd0);
        chk("r36_pkt_in",  64'(bus.PACKET_OUT_IN), 64'd0);
        chk("r36_cnt_ex",  64'(bus.CNT_EX), 64'd0);
        chk("r36_cnt_in",  64'(bus.CNT_IN), 64'd0);
        #1;
        mr_n = 1'b1;
        @(negedge clk);
        step(1'b1, {6'd5, 32'h33}, 1'b0, 1'b0);
        chk("r36_post_accept", 64'(bus.PACKET_OUT_IN), 64'({6'd5, 32'h33}));
        step(1'b0, 38'd0, 1'b0, 1'b1);

        // Counter wrap on the EX route. Counters are zero after the reset above.
        for (int i = 0; i < 70000 && m_cnt_ex != 16'hFFFF; i++)
            step(1'b1, {6'd9, 32'(i)}, 1'b1, 1'b0);
        chk("r35_cnt_ffff", 64'(bus.CNT_EX), 64'hFFFF);
        step(1'b1, {6'd9, 32'hFFFF_0000}, 1'b1, 1'b0);
        chk("r35_cnt_wrap", 64'(bus.CNT_EX), 64'h0000);
        step(1'b0, 38'd0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
